// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered clock, frame
// decoder with parity/framing/timeout checks, and a first-word fall-through byte FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 5,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    input  logic                         rd_en,
    output logic [7:0]                   out,
    output logic                         valid,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         parity_err,
    output logic                         frame_err,
    output logic                         overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_e;

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_q, filt_d, fall_q, fall_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [10:0]   shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          parity_err_q, parity_err_d, frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic          push_req, push_ok, do_pop, full;
    logic [7:0]    mem_q [FIFO_DEPTH];

    // Synchronisers and clock filter: the level flips only on the FILTER_LEN-th
    // consecutive differing sample; the strobe marks a filtered 1->0 flip.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_d = clk_s2_q;
                fall_d = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Frame decoder; shift_q ends as {stop, parity, data[7:0], start}.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tmo_d        = tmo_q;
        push_req     = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_q) begin
                    if (!dat_s2_q) begin
                        shift_d   = {1'b0, shift_q[10:1]};
                        bit_cnt_d = '0;
                        tmo_d     = TW'(1);
                        state_d   = RECV;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (fall_q) begin
                    shift_d   = {dat_s2_q, shift_q[10:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmo_d     = TW'(1);
                    if (bit_cnt_q == 4'd9) state_d = CHECK;
                end else if (tmo_q == TMO_MAX) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!shift_q[10] || shift_q[0]) frame_err_d  = 1'b1;
                else if (!(^shift_q[9:1]))      parity_err_d = 1'b1;
                else                            push_req     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop     = rd_en && (count_q != '0);
        full       = (count_q == DEPTH_C);
        push_ok    = push_req && (!full || do_pop);
        overflow_d = push_req && full && !do_pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({push_ok, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            fall_q       <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            dat_s1_q     <= dat_s1_d;
            dat_s2_q     <= dat_s2_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            fall_q       <= fall_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    // NOTE: storage is not reset; count_q alone defines which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q[8:1];
    end

    assign valid      = (count_q != '0);
    assign out        = valid ? mem_q[rd_ptr_q] : 8'h00;
    assign count      = count_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on ps2_clk/ps2_data and
// outputs are compared with hand-computed values.
module tb_ps2_rx_fifo;
    localparam int FL   = 5;
    localparam int D    = 8;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] out;
    logic       valid;
    logic [3:0] count;
    logic       parity_err, frame_err, overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fall_cyc = -1000, frm_cyc = -1000, vrise_cyc = -1000;
    int n_par = 0, n_frm = 0, n_ovf = 0;
    logic vprev = 1'b0;

    ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .out(out), .valid(valid), .count(count),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Event monitor: records the cycle index of strobes, pulses and valid rises.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (dut.fall_q) fall_cyc = cyc;
        if (parity_err) n_par++;
        if (frame_err) begin n_frm++; frm_cyc = cyc; end
        if (overflow) n_ovf++;
        if (valid && !vprev) vrise_cyc = cyc;
        vprev = valid;
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        n_par = 0; n_frm = 0; n_ovf = 0; vrise_cyc = -1000; frm_cyc = -1000;
    endtask

    task automatic ps2_bit(input logic b, input bit glitch, input bit pop_sync);
        int start_fall;
        int seen;
        ps2_data = b;
        if (glitch) begin
            wait_neg(8);
            ps2_clk = 1'b0;
            wait_neg(FL - 1);
            ps2_clk = 1'b1;
            wait_neg(HALF - 8 - (FL - 1));
        end else begin
            wait_neg(HALF);
        end
        ps2_clk = 1'b0;
        start_fall = fall_cyc;
        seen = -1;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            if (pop_sync) begin
                if (seen < 0 && fall_cyc != start_fall) seen = i;
                rd_en = (seen >= 0 && i == seen + 1);
            end
        end
        if (pop_sync) rd_en = 1'b0;
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input bit pop_sync);
        ps2_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch, 1'b0);
        ps2_bit((~^b) ^ bad_par, glitch, 1'b0);
        ps2_bit(~bad_stop, glitch, pop_sync);
        ps2_data = 1'b1;
        wait_neg(10);
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0, 1'b0, 1'b0);
        for (int i = 1; i < nbits; i++) ps2_bit(i[0], 1'b0, 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_neg(4);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
        checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {parity_err, frame_err, overflow}); end
        rst_n = 1'b1;
        wait_neg(4);
    endtask

    task automatic test_good_frame();
        clear_mon();
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (vrise_cyc - fall_cyc !== 2) begin errors++; $display("FAIL good_latency: got %0d expected 2", vrise_cyc - fall_cyc); end
        checks++; if (out !== 8'h1C) begin errors++; $display("FAIL good_out: got %h expected 1c", out); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL good_count: got %0d expected 1", count); end
        checks++; if (n_par + n_frm + n_ovf !== 0) begin errors++; $display("FAIL good_pulses: got %0d expected 0", n_par + n_frm + n_ovf); end
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL good_pop_valid: got %b expected 0", valid); end
    endtask

    task automatic test_parity();
        clear_mon();
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (n_par !== 1) begin errors++; $display("FAIL par_pulses: got %0d expected 1", n_par); end
        checks++; if (n_frm !== 0) begin errors++; $display("FAIL par_frame: got %0d expected 0", n_frm); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL par_count: got %0d expected 0", count); end
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out !== 8'hF0) begin errors++; $display("FAIL par_next_out: got %h expected f0", out); end
        checks++; if (n_par !== 1) begin errors++; $display("FAIL par_next_pulses: got %0d expected 1", n_par); end
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic test_frame_errors();
        clear_mon();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (n_frm !== 1) begin errors++; $display("FAIL both_frame: got %0d expected 1", n_frm); end
        checks++; if (n_par !== 0) begin errors++; $display("FAIL both_parity: got %0d expected 0", n_par); end
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (n_frm !== 2) begin errors++; $display("FAIL stop_frame: got %0d expected 2", n_frm); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL stop_count: got %0d expected 0", count); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        clear_mon();
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_fill_count: got %0d expected 8", count); end
        checks++; if (n_ovf !== 0) begin errors++; $display("FAIL ovf_early: got %0d expected 0", n_ovf); end
        send_frame(8'h09, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (n_ovf !== 1) begin errors++; $display("FAIL ovf_pulse: got %0d expected 1", n_ovf); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        checks++; if (out !== 8'h01) begin errors++; $display("FAIL ovf_head: got %h expected 01", out); end
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            checks++; if (out !== b) begin errors++; $display("FAIL ovf_pop_%0d: got %h expected %h", i, out, b); end
            rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_empty_valid: got %b expected 0", valid); end
        rd_en = 1'b1; wait_neg(3); rd_en = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL underflow_count: got %0d expected 0", count); end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_partial(5);
        wait_neg(TMO + 40);
        checks++; if (n_frm !== 1) begin errors++; $display("FAIL tmo_pulses: got %0d expected 1", n_frm); end
        checks++; if (frm_cyc - fall_cyc !== TMO) begin errors++; $display("FAIL tmo_delay: got %0d expected %0d", frm_cyc - fall_cyc, TMO); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out !== 8'h5A || count !== 4'd1) begin errors++; $display("FAIL tmo_next: got %h/%0d expected 5a/1", out, count); end
        checks++; if (n_frm !== 1 || n_par !== 0) begin errors++; $display("FAIL tmo_next_err: got %0d/%0d expected 1/0", n_frm, n_par); end
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic test_glitch();
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (out !== 8'hA5 || count !== 4'd1) begin errors++; $display("FAIL glitch_byte: got %h/%0d expected a5/1", out, count); end
        checks++; if (n_par + n_frm !== 0) begin errors++; $display("FAIL glitch_err: got %0d expected 0", n_par + n_frm); end
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic test_full_rw();
        logic [7:0] b;
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            b = 8'h10 + 8'(i);
            send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send_frame(8'h18, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL rw_count: got %0d expected 8", count); end
        checks++; if (n_ovf !== 0) begin errors++; $display("FAIL rw_overflow: got %0d expected 0", n_ovf); end
        for (int i = 1; i <= 8; i++) begin
            b = 8'h10 + 8'(i);
            checks++; if (out !== b) begin errors++; $display("FAIL rw_pop_%0d: got %h expected %h", i, out, b); end
            rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rw_empty: got %b expected 0", valid); end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        send_partial(5);
        rst_n = 1'b0;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(TMO + 20);
        checks++; if (n_frm + n_par !== 0) begin errors++; $display("FAIL rstmid_err: got %0d expected 0", n_frm + n_par); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out !== 8'h3C || count !== 4'd1) begin errors++; $display("FAIL rstmid_next: got %h/%0d expected 3c/1", out, count); end
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity();
        test_frame_errors();
        test_overflow();
        test_timeout();
        test_glitch();
        test_full_rw();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 5: consecutive identical synchronised ps2_clk samples required to change the filtered clock level (2..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: received-byte buffer depth (power of two, 2..64).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000: clk cycles allowed between successive filtered falling edges inside a frame.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port ps2_clk, input, 1, asynchronous PS/2 clock line.
REQ-007 SHALL have port ps2_data, input, 1, asynchronous PS/2 data line.
REQ-008 SHALL have port rd_en, input, 1, pop the FIFO head.
REQ-009 SHALL have port out, output, 8, FIFO head byte (first-word fall-through).
REQ-010 SHALL have port valid, output, 1, FIFO non-empty.
REQ-011 SHALL have port count, output, clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-012 SHALL have port parity_err, output, 1, one-cycle pulse on a bad parity bit.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse on a bad start/stop bit or timeout.
REQ-014 SHALL have port overflow, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-015 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers before any use.
REQ-016 SHALL change the filtered clock level only after FILTER_LEN consecutive equal synchronised samples; shorter pulses SHALL be ignored.
REQ-017 SHALL generate a one-cycle fall strobe on each filtered 1->0 transition and sample synchronised ps2_data in that same cycle.
REQ-018 SHALL use FSM states IDLE, RECV, CHECK; reset state is IDLE.
REQ-019 IDLE: on fall strobe with data 0, clear bit counter, start timeout counter, go to RECV; with data 1, pulse frame_err and stay in IDLE.
REQ-020 RECV: shift each sampled bit in LSB-first; after the 11th bit (start, 8 data, odd parity, stop) go to CHECK.
REQ-021 RECV: timeout counter SHALL reload on each fall strobe; on reaching TIMEOUT_CYCLES without a strobe, pulse frame_err, discard the partial frame, go to IDLE.
REQ-022 CHECK (one cycle): stop bit 0 -> frame_err; else parity odd-check fails -> parity_err; else push the byte; in all cases go to IDLE.
REQ-023 Only one error pulse per frame; a frame with both stop and parity faults SHALL report frame_err only.
REQ-024 Latency: valid SHALL rise exactly 2 clk cycles after the stop-bit fall strobe when the FIFO was empty.
REQ-025 Push when count==FIFO_DEPTH and rd_en low: drop the byte, pulse overflow, FIFO contents unchanged.
REQ-026 Push when full with rd_en high in the same cycle: both SHALL succeed, count unchanged, no overflow.
REQ-027 rd_en while valid low SHALL be ignored; count SHALL never underflow.
REQ-028 out SHALL hold the oldest unread byte whenever valid is high; its value while valid is low is don't-care.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 While rst_n is low at a clk edge: FSM to IDLE, FIFO emptied (count 0, valid 0), out 8'h00, all error pulses 0, filters preset to level 1, counters cleared.
REQ-031 Reset mid-frame SHALL discard the partial frame without an error pulse; the next complete frame after rst_n rises SHALL be received normally.

Verification
REQ-032 Frame 0x1C, parity 0, stop 1 -> valid rises 2 cycles after the stop strobe, out=8'h1C, count=1, no error pulses.
REQ-033 Frame 0x1C with parity 1 -> single parity_err pulse, count stays 0; following good 0xF0 frame (parity 1) -> out=8'hF0.
REQ-034 Nine good frames 0x01..0x09, rd_en low, depth 8 -> count=8, one overflow pulse on the 9th, out=8'h01; eight pops yield 0x01..0x08, then valid=0.
REQ-035 Five bits then an idle line -> frame_err exactly TIMEOUT_CYCLES after the 5th strobe, FSM IDLE; the next 0x5A frame is received correctly.
REQ-036 Low glitches of FILTER_LEN-1 cycles on ps2_clk during a frame -> no extra bits, byte received unchanged.
REQ-037 Push while full with simultaneous rd_en -> count stays 8, no overflow, new byte emerges last.
